// File: rtl/alu_seq_pkg.sv
// Shared opcodes, state encoding and control bundle
// for the ALU op sequencer and its decoder.
package alu_seq_pkg;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_SHR  = 5'b00101;
  localparam logic [4:0] OPC_SHRA = 5'b00110;
  localparam logic [4:0] OPC_SHL  = 5'b00111;
  localparam logic [4:0] OPC_ROR  = 5'b01000;
  localparam logic [4:0] OPC_ROL  = 5'b01001;
  localparam logic [4:0] OPC_AND  = 5'b01010;
  localparam logic [4:0] OPC_OR   = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;

  localparam int B_ADD  = 12;
  localparam int B_SUB  = 11;
  localparam int B_MUL  = 10;
  localparam int B_DIV  = 9;
  localparam int B_AND  = 8;
  localparam int B_OR   = 7;
  localparam int B_SHR  = 6;
  localparam int B_SHRA = 5;
  localparam int B_SHL  = 4;
  localparam int B_ROR  = 3;
  localparam int B_ROL  = 2;
  localparam int B_NEG  = 1;
  localparam int B_NOT  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    CL_ILL,
    CL_BIN,
    CL_UNA,
    CL_WIDE
  } op_class_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic [12:0] alu_op;
    logic        src_a_out;
    logic        src_b_out;
    logic        y_in;
    logic        z_in;
    logic        zlow_out;
    logic        zhigh_out;
    logic        dst_in;
    logic        lo_in;
    logic        hi_in;
  } ctl_t;

  function automatic op_class_t op_class(
    input logic [4:0] op
  );
    op_class_t c;
    unique case (op)
      OPC_MUL, OPC_DIV: c = CL_WIDE;
      OPC_NEG, OPC_NOT: c = CL_UNA;
      OPC_ADD, OPC_SUB, OPC_SHR,
      OPC_SHRA, OPC_SHL, OPC_ROR,
      OPC_ROL, OPC_AND, OPC_OR:
        c = CL_BIN;
      default: c = CL_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> one-hot ALU
// strobe plus operation class (binary/unary/wide/illegal).
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0]  opcode,
  output logic [12:0] onehot,
  output op_class_t   cls
);

  always_comb begin
    cls    = op_class(opcode);
    onehot = '0;
    unique case (1'b1)
      (opcode == OPC_ADD):  onehot[B_ADD]  = 1'b1;
      (opcode == OPC_SUB):  onehot[B_SUB]  = 1'b1;
      (opcode == OPC_MUL):  onehot[B_MUL]  = 1'b1;
      (opcode == OPC_DIV):  onehot[B_DIV]  = 1'b1;
      (opcode == OPC_AND):  onehot[B_AND]  = 1'b1;
      (opcode == OPC_OR):   onehot[B_OR]   = 1'b1;
      (opcode == OPC_SHR):  onehot[B_SHR]  = 1'b1;
      (opcode == OPC_SHRA): onehot[B_SHRA] = 1'b1;
      (opcode == OPC_SHL):  onehot[B_SHL]  = 1'b1;
      (opcode == OPC_ROR):  onehot[B_ROR]  = 1'b1;
      (opcode == OPC_ROL):  onehot[B_ROL]  = 1'b1;
      (opcode == OPC_NEG):  onehot[B_NEG]  = 1'b1;
      (opcode == OPC_NOT):  onehot[B_NOT]  = 1'b1;
      default:              onehot = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control sequencer: T3..T6 register-transfer steps.
// Ports: clock/clear(sync, high), start/opcode in; busy,
// done, illegal, alu_op one-hot and bus/register enables
// out. ALU_SEQ_STATS_EN adds op_count (completed ops).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MULDIV_WAIT = 2,
  parameter int OP_W        = 5
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [12:0]     alu_op,
  output logic            src_a_out,
  output logic            src_b_out,
  output logic            y_in,
  output logic            z_in,
  output logic            zlow_out,
  output logic            zhigh_out,
  output logic            dst_in,
  output logic            lo_in,
  output logic            hi_in
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]     op_count
`endif
);

  localparam logic [3:0] WAIT4 = 4'(MULDIV_WAIT);

  state_t          state_q, state_d;
  logic [OP_W-1:0] opc_q, opc_d;
  logic [3:0]      cnt_q, cnt_d;
  ctl_t            ctl_q, ctl_d;
  logic [12:0]     onehot_d;
  op_class_t       cls_d;
  logic            take;
  logic            wide;

  // Outputs are computed from the next state so that
  // the registered enables line up with the state.
  assign take  = (state_q == S_IDLE) && start;
  assign opc_d = take ? opcode : opc_q;
  assign wide  = (cls_d == CL_WIDE);

  alu_op_decode u_dec (
    .opcode (opc_d),
    .onehot (onehot_d),
    .cls    (cls_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (cls_d)
            CL_ILL:  state_d = S_ERR;
            CL_UNA:  state_d = S_T4;
            default: state_d = S_T3;
          endcase
        end
      end
      S_T3: state_d = S_T4;
      S_T4: begin
        if (wide && cnt_q != 4'd0)
          cnt_d = cnt_q - 4'd1;
        else
          state_d = S_T5;
      end
      S_T5: state_d = wide ? S_T6 : S_DONE;
      S_T6: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_T4 && state_q != S_T4)
      cnt_d = WAIT4;

    ctl_d.busy = (state_d != S_IDLE);
    unique case (state_d)
      S_T3: begin
        ctl_d.src_a_out = 1'b1;
        ctl_d.y_in      = 1'b1;
      end
      S_T4: begin
        ctl_d.src_b_out = 1'b1;
        ctl_d.alu_op    = onehot_d;
        ctl_d.z_in      = !wide || (cnt_d == 4'd0);
      end
      S_T5: begin
        ctl_d.zlow_out = 1'b1;
        ctl_d.dst_in   = !wide;
        ctl_d.lo_in    = wide;
      end
      S_T6: begin
        ctl_d.zhigh_out = 1'b1;
        ctl_d.hi_in     = 1'b1;
      end
      S_DONE:  ctl_d.done    = 1'b1;
      S_ERR:   ctl_d.illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clock) begin
    if (clear)
      op_count <= '0;
    else if (state_d == S_DONE)
      op_count <= op_count + 16'd1;
  end
`endif

  assign busy      = ctl_q.busy;
  assign done      = ctl_q.done;
  assign illegal   = ctl_q.illegal;
  assign alu_op    = ctl_q.alu_op;
  assign src_a_out = ctl_q.src_a_out;
  assign src_b_out = ctl_q.src_b_out;
  assign y_in      = ctl_q.y_in;
  assign z_in      = ctl_q.z_in;
  assign zlow_out  = ctl_q.zlow_out;
  assign zhigh_out = ctl_q.zhigh_out;
  assign dst_in    = ctl_q.dst_in;
  assign lo_in     = ctl_q.lo_in;
  assign hi_in     = ctl_q.hi_in;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a queue-based
// per-cycle model of the expected control outputs.
module tb_alu_op_sequencer;

  localparam int W = 2;

  localparam logic [24:0] M_HI   = 25'h1;
  localparam logic [24:0] M_LO   = 25'h2;
  localparam logic [24:0] M_DST  = 25'h4;
  localparam logic [24:0] M_ZHI  = 25'h8;
  localparam logic [24:0] M_ZLO  = 25'h10;
  localparam logic [24:0] M_Z    = 25'h20;
  localparam logic [24:0] M_Y    = 25'h40;
  localparam logic [24:0] M_SB   = 25'h80;
  localparam logic [24:0] M_SA   = 25'h100;
  localparam logic [24:0] M_ILL  = 25'h400000;
  localparam logic [24:0] M_DONE = 25'h800000;
  localparam logic [24:0] M_BUSY = 25'h1000000;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic        busy, done, illegal;
  logic [12:0] alu_op;
  logic        src_a_out, src_b_out, y_in, z_in;
  logic        zlow_out, zhigh_out, dst_in, lo_in, hi_in;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count;
  logic [15:0] cnt_m = 16'd0;
`endif

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  int bit_of [32];
  logic [4:0] legal [13];
  logic [24:0] q [$];

  always #5 clock = ~clock;

  alu_op_sequencer #(
    .MULDIV_WAIT (W),
    .OP_W        (5)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .opcode    (opcode),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .alu_op    (alu_op),
    .src_a_out (src_a_out),
    .src_b_out (src_b_out),
    .y_in      (y_in),
    .z_in      (z_in),
    .zlow_out  (zlow_out),
    .zhigh_out (zhigh_out),
    .dst_in    (dst_in),
    .lo_in     (lo_in),
    .hi_in     (hi_in)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               name, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one accepted request.
  task automatic push_seq(input logic [4:0] op);
    int b;
    int n;
    bit una, wid;
    logic [24:0] a;
    b = bit_of[op];
    if (b < 0) begin
      q.push_back(M_BUSY | M_ILL);
      return;
    end
    una = (b == 1) || (b == 0);
    wid = (b == 10) || (b == 9);
    a = 25'd1 << (9 + b);
    if (!una) q.push_back(M_BUSY | M_SA | M_Y);
    n = wid ? W + 1 : 1;
    for (int i = 0; i < n; i++)
      q.push_back(M_BUSY | M_SB | a |
                  ((i == n - 1) ? M_Z : 25'd0));
    q.push_back(M_BUSY | M_ZLO |
                (wid ? M_LO : M_DST));
    if (wid) q.push_back(M_BUSY | M_ZHI | M_HI);
    q.push_back(M_BUSY | M_DONE);
  endtask

  always @(negedge clock) begin : cmp
    logic [24:0] e;
    logic [24:0] g;
    bit idle;
    if (armed) begin
      idle = (q.size() == 0);
      e = 25'd0;
      if (!idle) e = q.pop_front();
      g = {busy, done, illegal, alu_op,
           src_a_out, src_b_out, y_in, z_in,
           zlow_out, zhigh_out, dst_in, lo_in, hi_in};
      chk("cycle", 32'(g), 32'(e));
`ifdef ALU_SEQ_STATS_EN
      if (e[23]) cnt_m = cnt_m + 16'd1;
      chk("op_count", 32'(op_count), 32'(cnt_m));
      if (clear) cnt_m = 16'd0;
`endif
      if (clear) q.delete();
      else if (idle && start) push_seq(opcode);
    end
  end

  task automatic go(input logic [4:0] op);
    start  = 1'b1;
    opcode = op;
    @(posedge clock); #1;
    start  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bit_of[i] = -1;
    bit_of[5'b00011] = 12; bit_of[5'b00100] = 11;
    bit_of[5'b01111] = 10; bit_of[5'b10000] = 9;
    bit_of[5'b01010] = 8;  bit_of[5'b01011] = 7;
    bit_of[5'b00101] = 6;  bit_of[5'b00110] = 5;
    bit_of[5'b00111] = 4;  bit_of[5'b01000] = 3;
    bit_of[5'b01001] = 2;  bit_of[5'b10001] = 1;
    bit_of[5'b10010] = 0;
    legal = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
              5'b00111, 5'b01000, 5'b01001, 5'b01010,
              5'b01011, 5'b01111, 5'b10000, 5'b10001,
              5'b10010};

    repeat (2) @(posedge clock);
    #1 armed = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_alu", 32'(alu_op), 32'd0);
    idle_cycles(1);

    // ADD
    go(5'b00011);
    @(negedge clock);
    chk("add_t3", {29'd0, y_in, src_a_out, busy}, 32'd7);
    @(negedge clock);
    chk("add_t4", {18'd0, alu_op, z_in}, {18'd0, 13'h1000, 1'b1});
    @(negedge clock);
    chk("add_t5", {30'd0, zlow_out, dst_in}, 32'd3);
    @(negedge clock);
    chk("add_done", 32'(done), 32'd1);
    @(negedge clock);
    chk("add_idle", 32'(busy), 32'd0);
    idle_cycles(1);

    // MUL
    go(5'b01111);
    @(negedge clock);
    chk("mul_t3", 32'(y_in), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("mul_t4", {18'd0, alu_op, z_in},
          {18'd0, 13'h0400, (i == 2)});
    end
    @(negedge clock);
    chk("mul_t5", {29'd0, zlow_out, lo_in, dst_in}, 32'd6);
    @(negedge clock);
    chk("mul_t6", {30'd0, zhigh_out, hi_in}, 32'd3);
    @(negedge clock);
    chk("mul_done", 32'(done), 32'd1);
    idle_cycles(1);

    // NOT
    go(5'b10010);
    @(negedge clock);
    chk("not_t4", {18'd0, alu_op, y_in}, {18'd0, 13'h0001, 1'b0});
    @(negedge clock);
    chk("not_t5", 32'(dst_in), 32'd1);
    @(negedge clock);
    chk("not_done", 32'(done), 32'd1);
    idle_cycles(1);

    // Illegal
    go(5'b00000);
    @(negedge clock);
    chk("ill_pulse", {30'd0, illegal, busy}, 32'd3);
    chk("ill_noen", {19'd0, alu_op, src_a_out, y_in, src_b_out},
        32'd0);
    @(negedge clock);
    chk("ill_idle", {30'd0, illegal, busy}, 32'd0);
    idle_cycles(1);

    // Clear mid DIV; start while busy ignored
    start = 1'b1; opcode = 5'b10000;
    @(posedge clock); #1;
    opcode = 5'b00011;
    @(posedge clock); #1;
    start = 1'b0; clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    chk("clr_all", {7'd0, busy, done, illegal, alu_op,
        src_a_out, src_b_out, y_in, z_in, zlow_out,
        zhigh_out, dst_in, lo_in, hi_in}, 32'd0);
    idle_cycles(2);
    go(5'b00011);
    repeat (4) @(negedge clock);
    chk("post_clr_done", 32'(done), 32'd1);
    idle_cycles(2);

    // Random phase
    repeat (600) begin
      @(posedge clock); #1;
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 7)
        opcode = legal[$urandom_range(0, 12)];
      else
        opcode = 5'($urandom);
      clear = ($urandom_range(0, 49) == 0);
    end
    @(posedge clock); #1;
    start = 1'b0;
    clear = 1'b0;
    idle_cycles(20);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
